// File: rtl/dac_chirp_sequencer_pkg.sv
// dac_seq_pkg: state encoding, word-field layout and default command fields for dac_chirp_sequencer
package dac_seq_pkg;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_RAMP  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;
  localparam int CMD_LSB  = 20;
  localparam int ADDR_LSB = 16;
  localparam int CODE_W   = 16;
  localparam logic [3:0] DEF_CMD  = 4'h3;
  localparam logic [3:0] DEF_ADDR = 4'h0;
  function automatic logic [23:0] pack_word(input logic [3:0] cmd, input logic [3:0] addr, input logic [15:0] code);
    pack_word = (24'(cmd) << CMD_LSB) | (24'(addr) << ADDR_LSB) | 24'(code);
  endfunction
endpackage

// File: rtl/dac_chirp_sequencer_if.sv
// dac_chirp_sequencer_if: word/handshake bundle between the chirp sequencer and the SPI DAC serializer
interface dac_chirp_sequencer_if;
  logic [23:0] data;
  logic        start;
  logic        busy;
  logic        load;
  modport master(output data, output start, input busy, input load);
  modport slave(input data, input start, output busy, output load);
endinterface

// File: rtl/dac_chirp_sequencer_code_accum.sv
// dac_code_accum: ramp code accumulator that also packs the registered DAC command word
module dac_code_accum
  import dac_seq_pkg::*;
#(
  parameter logic [3:0] CMD  = DEF_CMD,
  parameter logic [3:0] ADDR = DEF_ADDR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step_en,
  input  logic [15:0] start_code,
  input  logic [15:0] step,
  output logic [23:0] word
);
  always_ff @(posedge clk)
    if (!rst_n) word <= '0;
    else if (load) word <= pack_word(CMD, ADDR, start_code);
    else if (step_en) word <= pack_word(CMD, ADDR, word[CODE_W-1:0] + step);
endmodule

// File: rtl/dac_chirp_sequencer.sv
// dac_chirp_sequencer: FMCW chirp frame sequencer driving an SPI DAC serializer; define DAC_CHIRP_SYNC_EN for the chirp_sync ADC trigger
module dac_chirp_sequencer
  import dac_seq_pkg::*;
#(
  parameter logic [3:0] CMD  = DEF_CMD,
  parameter logic [3:0] ADDR = DEF_ADDR
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        frame_start,
  input  logic                        abort,
  input  logic [15:0]                 cfg_start_code,
  input  logic [15:0]                 cfg_step,
  input  logic [15:0]                 cfg_nsteps,
  input  logic [7:0]                  cfg_nchirps,
  input  logic [15:0]                 cfg_idle_cycles,
  dac_chirp_sequencer_if.master       dac,
  output logic                        frame_busy,
  output logic                        chirp_active,
  output logic [7:0]                  chirp_idx,
  output logic                        frame_done,
  output logic                        chirp_sync
);
  logic [2:0]  state;
  logic [15:0] start_q, step_q, nsteps_q, idle_q, step_cnt, gap_cnt;
  logic [7:0]  nchirps_q;
  logic        aborted;
  logic        go, adv;
  assign go  = state == S_WAIT && !dac.busy && !abort;
  assign adv = state == S_RAMP && !abort && dac.load && step_cnt < nsteps_q;
  assign frame_busy   = state != S_IDLE;
  assign chirp_active = state == S_RAMP || state == S_DRAIN;
  dac_code_accum #(.CMD(CMD), .ADDR(ADDR)) u_accum (
    .clk(clk), .rst_n(rst_n), .load(go), .step_en(adv),
    .start_code(start_q), .step(step_q), .word(dac.data)
  );
  // abort outranks every state action, including a coincident dac_load
  always_ff @(posedge clk)
    if (!rst_n) begin
      state      <= S_IDLE;
      dac.start  <= 1'b0;
      chirp_idx  <= '0;
      frame_done <= 1'b0;
      aborted    <= 1'b0;
      step_cnt   <= '0;
      gap_cnt    <= '0;
      start_q    <= '0;
      step_q     <= '0;
      nsteps_q   <= '0;
      nchirps_q  <= '0;
      idle_q     <= '0;
    end else begin
      frame_done <= 1'b0;
      if (abort && state != S_IDLE) begin
        state     <= S_DRAIN;
        dac.start <= 1'b0;
        aborted   <= 1'b1;
      end else
        case (state)
          S_IDLE: if (frame_start) state <= S_LOAD;
          S_LOAD: begin
            start_q   <= cfg_start_code;
            step_q    <= cfg_step;
            nsteps_q  <= cfg_nsteps;
            nchirps_q <= cfg_nchirps;
            idle_q    <= cfg_idle_cycles;
            chirp_idx <= '0;
            aborted   <= 1'b0;
            frame_done <= cfg_nsteps == '0 || cfg_nchirps == '0;
            state     <= (cfg_nsteps == '0 || cfg_nchirps == '0) ? S_IDLE : S_WAIT;
          end
          S_WAIT: if (!dac.busy) begin
            dac.start <= 1'b1;
            step_cnt  <= 16'd1;
            state     <= S_RAMP;
          end
          S_RAMP: if (adv) step_cnt <= step_cnt + 16'd1;
            else if (dac.load) begin
              dac.start <= 1'b0;
              state     <= S_DRAIN;
            end
          S_DRAIN: if (!dac.busy) begin
            if (aborted || chirp_idx == nchirps_q - 8'd1) begin
              frame_done <= !aborted;
              state      <= S_IDLE;
            end else begin
              chirp_idx <= chirp_idx + 8'd1;
              gap_cnt   <= idle_q;
              state     <= S_GAP;
            end
          end
          S_GAP: begin
            gap_cnt <= gap_cnt - 16'd1;
            if (gap_cnt <= 16'd1) state <= S_WAIT;
          end
          default: state <= S_IDLE;
        endcase
    end
`ifdef DAC_CHIRP_SYNC_EN
  logic sync_q;
  always_ff @(posedge clk) sync_q <= rst_n && go;
  assign chirp_sync = sync_q;
`else
  assign chirp_sync = 1'b0;
`endif
endmodule
